// File: rtl/altsyncram.sv
// ---------------------------------------------------------------------------
// altsyncram -- single-port synchronous RAM with byte-lane writes.
//
// Only port A does anything. Address, write data and control are taken on
// the rising edge of clock0 when clocken0 is high. A read loads the addressed
// word into a read register. That register drives q_a directly
// (outdata_reg_a = "UNREGISTERED"), or through one more register
// (outdata_reg_a = "CLOCK0").
//
// Ports
//   clock0          sole clock, rising edge
//   aclr0_n         asynchronous active-low clear of the read/output registers
//   clocken0        clock enable for every port-A register and the memory
//   address_a       word address
//   data_a          write data
//   wren_a          write request
//   rden_a          read request
//   byteena_a       per-lane write enable, bit i covers data_a[i*byte_size +: byte_size]
//   addressstall_a  reuse the previously captured address
//   q_a             read data
//   address_b, data_b, wren_b, rden_b, byteena_b, clock1, clocken1..3,
//   addressstall_b, aclr1   accepted and ignored
//   q_b, eccstatus  tied to zero
//
// The design has no FSM and no valid/ready handshake. Every request is
// accepted on the enabled edge on which it is presented.
// ---------------------------------------------------------------------------
module altsyncram #(
    parameter int width_a         = 32,
    parameter int widthad_a       = 14,
    parameter int numwords_a      = 16384,
    parameter int byte_size       = 8,
    parameter int width_byteena_a = 4,
    parameter     outdata_reg_a   = "UNREGISTERED",
    parameter     init_file       = "",
    parameter     operation_mode  = "SINGLE_PORT"
) (
    input  logic                       clock0,
    input  logic                       aclr0_n,
    input  logic                       clocken0,
    input  logic [widthad_a-1:0]       address_a,
    input  logic [width_a-1:0]         data_a,
    input  logic                       wren_a,
    input  logic                       rden_a,
    input  logic [width_byteena_a-1:0] byteena_a,
    input  logic                       addressstall_a,
    output logic [width_a-1:0]         q_a,
    input  logic [widthad_a-1:0]       address_b,
    input  logic [width_a-1:0]         data_b,
    input  logic                       wren_b,
    input  logic                       rden_b,
    input  logic [width_byteena_a-1:0] byteena_b,
    input  logic                       clock1,
    input  logic                       clocken1,
    input  logic                       clocken2,
    input  logic                       clocken3,
    input  logic                       addressstall_b,
    input  logic                       aclr1,
    output logic [width_a-1:0]         q_b,
    output logic [2:0]                 eccstatus
);

    // Memory contents start at zero. init_file is carried so that existing
    // instantiations elaborate unchanged. operation_mode is carried for the
    // same reason, because only the single-port behaviour is built here.
    localparam bit unused_params = (init_file == "") || (operation_mode == "");

    // Port-B and auxiliary inputs have no function in this build.
    wire unused_inputs = &{1'b0, address_b, data_b, wren_b, rden_b, byteena_b,
                           clock1, clocken1, clocken2, clocken3,
                           addressstall_b, aclr1};

    assign q_b       = '0;
    assign eccstatus = '0;

    logic [width_a-1:0]   mem [numwords_a];
    logic [widthad_a-1:0] addr_reg;
    logic [widthad_a-1:0] eff_addr;
    logic                 in_range;
    logic [width_a-1:0]   rd_reg;

    // While addressstall_a is high, the access uses the address captured last
    // time instead of the new address_a.
    assign eff_addr = addressstall_a ? addr_reg : address_a;
    assign in_range = (32'(eff_addr) < 32'(numwords_a));

    // The memory array and the address register ignore reset. This keeps the
    // contents across a clear, and writes keep working while aclr0_n is low.
    always_ff @(posedge clock0) begin
        if (clocken0) begin
            addr_reg <= eff_addr;
            if (wren_a && in_range) begin
                for (int i = 0; i < width_byteena_a; i++) begin
                    if (byteena_a[i]) begin
                        mem[eff_addr][i*byte_size +: byte_size] <= data_a[i*byte_size +: byte_size];
                    end
                end
            end
        end
    end

    // The read register samples the array before this edge's write lands. A
    // read and a write to the same address therefore return the old word.
    always_ff @(posedge clock0 or negedge aclr0_n) begin
        if (!aclr0_n) begin
            rd_reg <= '0;
        end else if (clocken0 && rden_a) begin
            rd_reg <= in_range ? mem[eff_addr] : '0;
        end
    end

    if (outdata_reg_a == "CLOCK0") begin : g_out_reg
        logic [width_a-1:0] out_reg;

        always_ff @(posedge clock0 or negedge aclr0_n) begin
            if (!aclr0_n) begin
                out_reg <= '0;
            end else if (clocken0) begin
                out_reg <= rd_reg;
            end
        end

        assign q_a = out_reg;
    end else begin : g_out_direct
        assign q_a = rd_reg;
    end

endmodule

// File: tb/tb_altsyncram.sv
// ---------------------------------------------------------------------------
// Testbench for altsyncram. The same port-A inputs drive two instances: one
// with an unregistered output and one with "CLOCK0". The bench has three
// parts:
//   - a directed table of single-edge vectors with expected values worked
//     out by hand;
//   - a hand-written sequence for the asynchronous clear;
//   - a randomized run checked against a word/byte-level memory model.
// ---------------------------------------------------------------------------
module tb_altsyncram;

    localparam int AW = 6;
    localparam int NW = 40;

    // ---------------- clock / reset ----------------
    logic clock0 = 1'b0;
    always #5 clock0 = ~clock0;

    logic          aclr0_n;
    logic          clocken0;
    logic [AW-1:0] address_a;
    logic [31:0]   data_a;
    logic          wren_a;
    logic          rden_a;
    logic [3:0]    byteena_a;
    logic          addressstall_a;
    logic [AW-1:0] address_b;
    logic [31:0]   data_b;
    logic          wren_b, rden_b;
    logic [3:0]    byteena_b;
    logic          clock1, clocken1, clocken2, clocken3, addressstall_b, aclr1;
    logic [31:0]   q_u, q_r, qb_u, qb_r;
    logic [2:0]    ecc_u, ecc_r;

    altsyncram #(.widthad_a(AW), .numwords_a(NW), .outdata_reg_a("UNREGISTERED")) dut_u (
        .clock0(clock0), .aclr0_n(aclr0_n), .clocken0(clocken0),
        .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .rden_a(rden_a),
        .byteena_a(byteena_a), .addressstall_a(addressstall_a), .q_a(q_u),
        .address_b(address_b), .data_b(data_b), .wren_b(wren_b), .rden_b(rden_b),
        .byteena_b(byteena_b), .clock1(clock1), .clocken1(clocken1), .clocken2(clocken2),
        .clocken3(clocken3), .addressstall_b(addressstall_b), .aclr1(aclr1),
        .q_b(qb_u), .eccstatus(ecc_u));

    altsyncram #(.widthad_a(AW), .numwords_a(NW), .outdata_reg_a("CLOCK0")) dut_r (
        .clock0(clock0), .aclr0_n(aclr0_n), .clocken0(clocken0),
        .address_a(address_a), .data_a(data_a), .wren_a(wren_a), .rden_a(rden_a),
        .byteena_a(byteena_a), .addressstall_a(addressstall_a), .q_a(q_r),
        .address_b(address_b), .data_b(data_b), .wren_b(wren_b), .rden_b(rden_b),
        .byteena_b(byteena_b), .clock1(clock1), .clocken1(clocken1), .clocken2(clocken2),
        .clocken3(clocken3), .addressstall_b(addressstall_b), .aclr1(aclr1),
        .q_b(qb_r), .eccstatus(ecc_r));

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Each instance is modelled as a memory plus its read-pipeline depth.
    logic [31:0]   ref_mem [64];
    logic [AW-1:0] ref_addr;
    logic [31:0]   ref_rd;
    logic [31:0]   ref_out;

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        m = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) m = m | (32'hFF << (8 * i));
        end
        return m;
    endfunction

    // Updates the model from the inputs presented for the coming edge, then
    // waits for that edge and settles 1 time unit past it.
    task automatic tick();
        logic [AW-1:0] eff;
        logic [31:0]   old, m;
        eff = addressstall_a ? ref_addr : address_a;
        old = (int'(eff) < NW) ? ref_mem[eff] : 32'h0;
        m   = lane_mask(byteena_a);
        if (clocken0) begin
            ref_addr = eff;
            if (wren_a && int'(eff) < NW) ref_mem[eff] = (old & ~m) | (data_a & m);
            if (aclr0_n) begin
                ref_out = ref_rd;
                if (rden_a) ref_rd = old;
            end
        end
        if (!aclr0_n) begin
            ref_rd  = 32'h0;
            ref_out = 32'h0;
        end
        @(posedge clock0);
        #1;
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic en, input logic wr, input logic rd, input logic st,
                         input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
        clocken0       = en;
        wren_a         = wr;
        rden_a         = rd;
        addressstall_a = st;
        address_a      = a;
        data_a         = d;
        byteena_a      = be;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          en, wr, rd, st;
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    be;
        logic [31:0]   exp_u, exp_r;
    } vec_t;

    vec_t vecs [26];

    task automatic apply_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            drive(vecs[i].en, vecs[i].wr, vecs[i].rd, vecs[i].st, vecs[i].addr, vecs[i].data, vecs[i].be);
            tick();
            check($sformatf("row%0d_unreg", i), q_u, vecs[i].exp_u);
            check($sformatf("row%0d_reg", i), q_r, vecs[i].exp_r);
        end
    endtask

    initial begin
        //          en    wr    rd    st    addr  data           be    exp_u          exp_r
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 1'b0, 6'd5, 32'hDEADBEEF, 4'hF, 32'h0,         32'h0};
        vecs[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd5, 32'h0,        4'h0, 32'hDEADBEEF,  32'h0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd5, 32'h0,        4'h0, 32'hDEADBEEF,  32'hDEADBEEF};
        vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 6'd5, 32'h11223344, 4'h5, 32'hDEADBEEF,  32'hDEADBEEF};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd5, 32'h0,        4'h0, 32'hDE22BE44,  32'hDEADBEEF};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd5, 32'h0,        4'h0, 32'hDE22BE44,  32'hDE22BE44};
        // clocken0 low: nothing moves, including the attempted write to 6
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 6'd6, 32'h12345678, 4'hF, 32'hDE22BE44,  32'hDE22BE44};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd6, 32'h0,        4'h0, 32'h0,         32'hDE22BE44};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd5, 32'h0,        4'h0, 32'hDE22BE44,  32'h0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd5, 32'h0,        4'h0, 32'hDE22BE44,  32'hDE22BE44};
        // after the asynchronous clear (write to 8 happened during reset)
        vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd5, 32'h0,        4'h0, 32'hDE22BE44,  32'h0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd8, 32'h0,        4'h0, 32'h55AA55AA,  32'hDE22BE44};
        // read-during-write returns the old word
        vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 6'd7, 32'hA5A5A5A5, 4'hF, 32'h0,         32'h55AA55AA};
        vecs[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd7, 32'h0,        4'h0, 32'hA5A5A5A5,  32'h0};
        vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'd7, 32'h0,        4'h0, 32'hA5A5A5A5,  32'hA5A5A5A5};
        // address stall: new address ignored for reads and writes
        vecs[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd5, 32'h0,        4'h0, 32'hDE22BE44,  32'hA5A5A5A5};
        vecs[16] = '{1'b1, 1'b0, 1'b1, 1'b1, 6'd6, 32'h0,        4'h0, 32'hDE22BE44,  32'hDE22BE44};
        vecs[17] = '{1'b1, 1'b1, 1'b0, 1'b1, 6'd9, 32'hCAFEF00D, 4'hF, 32'hDE22BE44,  32'hDE22BE44};
        vecs[18] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd5, 32'h0,        4'h0, 32'hCAFEF00D,  32'hDE22BE44};
        // out-of-range addresses: write no-op, read zero
        vecs[19] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'd45, 32'hFFFFFFFF, 4'hF, 32'hCAFEF00D, 32'hCAFEF00D};
        vecs[20] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd45, 32'h0,        4'h0, 32'h0,        32'hCAFEF00D};
        vecs[21] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd40, 32'h0,        4'h0, 32'h0,        32'h0};
        // last valid word, partial lanes 1 and 3
        vecs[22] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'd39, 32'h01020304, 4'hA, 32'h0,        32'h0};
        vecs[23] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd39, 32'h0,        4'h0, 32'h01000300, 32'h0};
        // write with no lanes enabled leaves the word alone
        vecs[24] = '{1'b1, 1'b1, 1'b1, 1'b0, 6'd13, 32'hFFFFFFFF, 4'h0, 32'h0,        32'h01000300};
        vecs[25] = '{1'b1, 1'b0, 1'b1, 1'b0, 6'd13, 32'h0,        4'h0, 32'h0,        32'h0};
    end

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
        ref_addr = '0;
        ref_rd   = 32'h0;
        ref_out  = 32'h0;

        aclr0_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, 32'h0, 4'h0);
        address_b = '0; data_b = '0; wren_b = 1'b0; rden_b = 1'b0; byteena_b = '0;
        clock1 = 1'b0; clocken1 = 1'b0; clocken2 = 1'b0; clocken3 = 1'b0;
        addressstall_b = 1'b0; aclr1 = 1'b0;
        #1;
        check("reset_unreg", q_u, 32'h0);
        check("reset_reg", q_r, 32'h0);

        // Clear the words under test while held in reset. Writes must still
        // land, and the concurrent read requests must not reach q_a.
        for (int a = 0; a < NW; a++) begin
            drive(1'b1, 1'b1, 1'b1, 1'b0, AW'(a), 32'h0, 4'hF);
            tick();
        end
        check("reset_rd_suppressed_unreg", q_u, 32'h0);
        check("reset_rd_suppressed_reg", q_r, 32'h0);
        #2 aclr0_n = 1'b1;

        apply_rows(0, 9);

        // Asynchronous clear mid-cycle, with the clock enable low.
        #2;
        clocken0 = 1'b0;
        aclr0_n  = 1'b0;
        #1;
        check("aclr_immediate_unreg", q_u, 32'h0);
        check("aclr_immediate_reg", q_r, 32'h0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 6'd8, 32'h55AA55AA, 4'hF);
        tick();
        check("aclr_held_unreg", q_u, 32'h0);
        check("aclr_held_reg", q_r, 32'h0);
        #2 aclr0_n = 1'b1;

        apply_rows(10, 25);

        // Randomized traffic against the model, including random enable,
        // stall, out-of-range addresses, port-B noise and short clears.
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(7) != 0, $urandom_range(1) == 1, $urandom_range(1) == 1,
                  $urandom_range(7) == 0, AW'($urandom_range(47)), $urandom(),
                  4'($urandom_range(15)));
            aclr0_n   = ($urandom_range(39) != 0);
            address_b = AW'($urandom_range(63));
            data_b    = $urandom();
            wren_b    = 1'($urandom_range(1));
            rden_b    = 1'($urandom_range(1));
            clocken1  = 1'($urandom_range(1));
            tick();
            check("rand_unreg", q_u, ref_rd);
            check("rand_reg", q_r, ref_out);
        end
        check("q_b_unreg", qb_u, 32'h0);
        check("q_b_reg", qb_r, 32'h0);
        check("eccstatus", {29'h0, ecc_u | ecc_r}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
